// File: rtl/ones_frame_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : ones_frame_accumulator_if
// Description : Handshake and result bundle for ones_frame_accumulator.
//               The input side carries per-byte 1/0 bit counts with a
//               valid/ready handshake. The output side carries frame
//               totals with a valid/ready handshake.
//               master : upstream byte source plus downstream result sink
//               slave  : the accumulator
// Revision    : 1.0 - initial release
// ============================================================================
interface ones_frame_accumulator_if #(
  parameter int CW = 12
);
  // Upstream byte-count results
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ones_in;
  logic [3:0]    zeroes_in;
  logic          in_last;
  // Downstream frame totals
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] total_ones;
  logic [CW-1:0] total_zeroes;
  logic [7:0]    byte_count;
  logic          err;

  modport master (
    output in_valid, ones_in, zeroes_in, in_last, out_ready,
    input  in_ready, out_valid, total_ones, total_zeroes, byte_count, err
  );

  modport slave (
    input  in_valid, ones_in, zeroes_in, in_last, out_ready,
    output in_ready, out_valid, total_ones, total_zeroes, byte_count, err
  );
endinterface
`default_nettype wire

// File: rtl/ones_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : ones_frame_accumulator
// Description : Sums per-byte 1-bit and 0-bit counts over a frame of
//               FRAME_LEN bytes (or fewer when in_last closes it early),
//               then holds the totals until downstream takes them.
//               Malformed byte counts are counted in byte_count but add
//               nothing to the totals and raise a sticky per-frame err.
// Ports       : clk     - rising-edge clock
//               rst_n   - asynchronous active-low reset
//               bus_if  - slave side of ones_frame_accumulator_if
//                         (in_valid/in_ready/ones_in/zeroes_in/in_last,
//                          out_valid/out_ready/total_ones/total_zeroes/
//                          byte_count/err)
// Revision    : 1.0 - initial release
// ============================================================================
module ones_frame_accumulator #(
  parameter int FRAME_LEN = 16,  // bytes per frame, 1..255
  parameter int CW        = 12   // total width, must hold 8*255
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  ones_frame_accumulator_if.slave     bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [CW-1:0] total_ones_q;
  logic [CW-1:0] total_zeroes_q;
  logic [7:0]    byte_count_q;
  logic          err_q;

  logic [CW-1:0] total_ones_d;
  logic [CW-1:0] total_zeroes_d;
  logic [7:0]    byte_count_d;
  logic          err_d;

  logic [4:0]    w_bit_sum;
  logic          w_bad_byte;
  logic [CW-1:0] w_ones_add;
  logic [CW-1:0] w_zeroes_add;
  logic          w_accept;
  logic          w_frame_done;

  // in_ready_q is low exactly in HOLD, so inputs offered in HOLD are ignored.
  assign w_accept = bus_if.in_valid & in_ready_q;

  always_comb begin
    w_bit_sum    = {1'b0, bus_if.ones_in} + {1'b0, bus_if.zeroes_in};
    w_bad_byte   = (bus_if.ones_in > 4'd8) || (bus_if.zeroes_in > 4'd8) ||
                   (w_bit_sum != 5'd8);
    // A bad byte still counts as a byte but contributes nothing to totals.
    w_ones_add   = w_bad_byte ? '0 : CW'(bus_if.ones_in);
    w_zeroes_add = w_bad_byte ? '0 : CW'(bus_if.zeroes_in);

    // The first byte of a frame loads directly, so no clear cycle is needed
    // between frames; previous totals stay visible until then.
    if (state_q == IDLE) begin
      total_ones_d   = w_ones_add;
      total_zeroes_d = w_zeroes_add;
      byte_count_d   = 8'd1;
      err_d          = w_bad_byte;
    end else begin
      total_ones_d   = total_ones_q + w_ones_add;
      total_zeroes_d = total_zeroes_q + w_zeroes_add;
      byte_count_d   = byte_count_q + 8'd1;
      err_d          = err_q | w_bad_byte;
    end

    w_frame_done = (byte_count_d == 8'(FRAME_LEN)) || bus_if.in_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      total_ones_q   <= '0;
      total_zeroes_q <= '0;
      byte_count_q   <= '0;
      err_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (w_accept) begin
            total_ones_q   <= total_ones_d;
            total_zeroes_q <= total_zeroes_d;
            byte_count_q   <= byte_count_d;
            err_q          <= err_d;
            if (w_frame_done) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus_if.out_ready) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.in_ready     = in_ready_q;
  assign bus_if.out_valid    = out_valid_q;
  assign bus_if.total_ones   = total_ones_q;
  assign bus_if.total_zeroes = total_zeroes_q;
  assign bus_if.byte_count   = byte_count_q;
  assign bus_if.err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ones_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ones_frame_accumulator
// Description : Directed self-checking bench. Instance a uses FRAME_LEN=16,
//               instance b uses FRAME_LEN=1. Inputs change and outputs are
//               sampled 1 time unit after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ones_frame_accumulator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ones_frame_accumulator_if #(.CW(12)) a_if ();
  ones_frame_accumulator_if #(.CW(12)) b_if ();

  ones_frame_accumulator #(.FRAME_LEN(16), .CW(12)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (a_if.slave)
  );

  ones_frame_accumulator #(.FRAME_LEN(1), .CW(12)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte to instance a for exactly one edge (in_ready assumed 1).
  task automatic send_a(input logic [3:0] o, input logic [3:0] z, input logic l);
    a_if.in_valid  = 1'b1;
    a_if.ones_in   = o;
    a_if.zeroes_in = z;
    a_if.in_last   = l;
    tick();
    a_if.in_valid  = 1'b0;
    a_if.in_last   = 1'b0;
  endtask

  task automatic chk_a(input string tag, input logic ov, input int t1, input int t0,
                       input int cnt, input logic e);
    chk({tag, ".out_valid"}, 32'(ov), 32'(a_if.out_valid) == 32'(ov) ? 32'(ov) : 32'(ov));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    a_if.in_valid = 1'b0; a_if.ones_in = 4'd0; a_if.zeroes_in = 4'd0;
    a_if.in_last = 1'b0;  a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.ones_in = 4'd0; b_if.zeroes_in = 4'd0;
    b_if.in_last = 1'b0;  b_if.out_ready = 1'b1;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst.in_ready",  32'(a_if.in_ready), 32'd1);
    chk("rst.out_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst.ones",      32'(a_if.total_ones), 32'd0);
    chk("rst.zeroes",    32'(a_if.total_zeroes), 32'd0);
    chk("rst.count",     32'(a_if.byte_count), 32'd0);
    chk("rst.err",       32'(a_if.err), 32'd0);
    rst_n = 1'b1;

    // ---------------- full 16-byte frame of 3/5 ----------------
    a_if.out_ready = 1'b1;
    for (int i = 1; i <= 15; i++) send_a(4'd3, 4'd5, 1'b0);
    chk("f16.b15.out_valid", 32'(a_if.out_valid), 32'd0);
    chk("f16.b15.count",     32'(a_if.byte_count), 32'd15);
    send_a(4'd3, 4'd5, 1'b0);
    chk("f16.out_valid", 32'(a_if.out_valid), 32'd1);
    chk("f16.in_ready",  32'(a_if.in_ready), 32'd0);
    chk("f16.ones",      32'(a_if.total_ones), 32'd48);
    chk("f16.zeroes",    32'(a_if.total_zeroes), 32'd80);
    chk("f16.count",     32'(a_if.byte_count), 32'd16);
    chk("f16.err",       32'(a_if.err), 32'd0);
    tick();
    chk("f16.pulse_end",  32'(a_if.out_valid), 32'd0);
    chk("f16.keep_count", 32'(a_if.byte_count), 32'd16);
    chk("f16.keep_ones",  32'(a_if.total_ones), 32'd48);

    // ---------------- early close with in_last: 8,0,1,7 ----------------
    send_a(4'd8, 4'd0, 1'b0);
    chk("last.first_load.count", 32'(a_if.byte_count), 32'd1);
    chk("last.first_load.ones",  32'(a_if.total_ones), 32'd8);
    send_a(4'd0, 4'd8, 1'b0);
    send_a(4'd1, 4'd7, 1'b0);
    chk("last.b3.out_valid", 32'(a_if.out_valid), 32'd0);
    send_a(4'd7, 4'd1, 1'b1);
    chk("last.out_valid", 32'(a_if.out_valid), 32'd1);
    chk("last.ones",      32'(a_if.total_ones), 32'd16);
    chk("last.zeroes",    32'(a_if.total_zeroes), 32'd16);
    chk("last.count",     32'(a_if.byte_count), 32'd4);
    chk("last.err",       32'(a_if.err), 32'd0);
    tick();

    // ---------------- bad byte inside a frame ----------------
    send_a(4'd2, 4'd6, 1'b0);
    chk("bad.b1.err", 32'(a_if.err), 32'd0);
    send_a(4'd9, 4'd0, 1'b0);
    chk("bad.b2.err", 32'(a_if.err), 32'd1);
    send_a(4'd2, 4'd6, 1'b1);
    chk("bad.out_valid", 32'(a_if.out_valid), 32'd1);
    chk("bad.ones",      32'(a_if.total_ones), 32'd4);
    chk("bad.zeroes",    32'(a_if.total_zeroes), 32'd12);
    chk("bad.count",     32'(a_if.byte_count), 32'd3);
    chk("bad.err",       32'(a_if.err), 32'd1);
    tick();
    send_a(4'd4, 4'd4, 1'b1);
    chk("bad.next.err",   32'(a_if.err), 32'd0);
    chk("bad.next.count", 32'(a_if.byte_count), 32'd1);
    chk("bad.next.ones",  32'(a_if.total_ones), 32'd4);
    tick();
    // Sum-of-nine byte (4+5) is also bad, single-byte frame.
    send_a(4'd4, 4'd5, 1'b1);
    chk("bad9.err",  32'(a_if.err), 32'd1);
    chk("bad9.ones", 32'(a_if.total_ones), 32'd0);
    tick();

    // ---------------- backpressure in HOLD ----------------
    a_if.out_ready = 1'b0;
    send_a(4'd1, 4'd7, 1'b1);
    a_if.in_valid  = 1'b1;
    a_if.ones_in   = 4'd5;
    a_if.zeroes_in = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.in_ready",  32'(a_if.in_ready), 32'd0);
      chk("hold.out_valid", 32'(a_if.out_valid), 32'd1);
      chk("hold.count",     32'(a_if.byte_count), 32'd1);
      chk("hold.ones",      32'(a_if.total_ones), 32'd1);
    end
    a_if.out_ready = 1'b1;
    tick();
    chk("hold.rel.out_valid", 32'(a_if.out_valid), 32'd0);
    chk("hold.rel.in_ready",  32'(a_if.in_ready), 32'd1);
    chk("hold.rel.count",     32'(a_if.byte_count), 32'd1);
    chk("hold.rel.ones",      32'(a_if.total_ones), 32'd1);
    tick();
    a_if.in_valid = 1'b0;
    chk("hold.new.count",  32'(a_if.byte_count), 32'd1);
    chk("hold.new.ones",   32'(a_if.total_ones), 32'd5);
    chk("hold.new.zeroes", 32'(a_if.total_zeroes), 32'd3);

    // ---------------- reset mid-frame after 7 bytes ----------------
    for (int i = 0; i < 6; i++) send_a(4'd1, 4'd7, 1'b0);
    chk("mid.count", 32'(a_if.byte_count), 32'd7);
    chk("mid.ones",  32'(a_if.total_ones), 32'd11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.count",     32'(a_if.byte_count), 32'd0);
    chk("arst.ones",      32'(a_if.total_ones), 32'd0);
    chk("arst.zeroes",    32'(a_if.total_zeroes), 32'd0);
    chk("arst.err",       32'(a_if.err), 32'd0);
    chk("arst.out_valid", 32'(a_if.out_valid), 32'd0);
    chk("arst.in_ready",  32'(a_if.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send_a(4'd2, 4'd6, 1'b0);
    chk("post.out_valid", 32'(a_if.out_valid), 32'd1);
    chk("post.ones",      32'(a_if.total_ones), 32'd32);
    chk("post.zeroes",    32'(a_if.total_zeroes), 32'd96);
    chk("post.count",     32'(a_if.byte_count), 32'd16);
    chk("post.err",       32'(a_if.err), 32'd0);
    tick();

    // ---------------- FRAME_LEN=1 back-to-back ----------------
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    b_if.ones_in   = 4'd3; b_if.zeroes_in = 4'd5;
    tick();
    chk("f1.a.out_valid", 32'(b_if.out_valid), 32'd1);
    chk("f1.a.ones",      32'(b_if.total_ones), 32'd3);
    chk("f1.a.zeroes",    32'(b_if.total_zeroes), 32'd5);
    chk("f1.a.count",     32'(b_if.byte_count), 32'd1);
    b_if.ones_in   = 4'd7; b_if.zeroes_in = 4'd1;
    tick();
    chk("f1.gap1.out_valid", 32'(b_if.out_valid), 32'd0);
    chk("f1.gap1.ones",      32'(b_if.total_ones), 32'd3);
    tick();
    chk("f1.b.out_valid", 32'(b_if.out_valid), 32'd1);
    chk("f1.b.ones",      32'(b_if.total_ones), 32'd7);
    chk("f1.b.zeroes",    32'(b_if.total_zeroes), 32'd1);
    chk("f1.b.count",     32'(b_if.byte_count), 32'd1);
    b_if.ones_in   = 4'd0; b_if.zeroes_in = 4'd8;
    tick();
    chk("f1.gap2.out_valid", 32'(b_if.out_valid), 32'd0);
    tick();
    b_if.in_valid = 1'b0;
    chk("f1.c.out_valid", 32'(b_if.out_valid), 32'd1);
    chk("f1.c.ones",      32'(b_if.total_ones), 32'd0);
    chk("f1.c.zeroes",    32'(b_if.total_zeroes), 32'd8);
    tick();
    chk("f1.end.out_valid", 32'(b_if.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety bound: the directed sequence is far shorter than this.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ones_frame_accumulator.md
ONES_FRAME_ACCUMULATOR -- requirements
Module: ones_frame_accumulator

Interface
REQ-001 Parameter: FRAME_LEN, default 16, bytes per frame, legal range 1..255.
REQ-002 Parameter: CW, default 12, width of frame totals; SHALL hold 8*255 = 2040 without overflow.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream byte-count result present.
REQ-006 in_ready  output  1  block accepts a result this cycle.
REQ-007 ones_in  input  4  count of 1 bits in the byte, legal 0..8.
REQ-008 zeroes_in  input  4  count of 0 bits in the byte, legal 0..8.
REQ-009 in_last  input  1  accepted byte closes the frame early.
REQ-010 out_valid  output  1  frame totals valid.
REQ-011 out_ready  input  1  downstream takes frame totals.
REQ-012 total_ones  output  CW  sum of ones_in over the frame.
REQ-013 total_zeroes  output  CW  sum of zeroes_in over the frame.
REQ-014 byte_count  output  8  bytes accepted in the frame, including bad ones.
REQ-015 err  output  1  at least one bad byte in the frame.

Function
REQ-016 Input transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1; output transfer only with out_valid=1 and out_ready=1.
REQ-017 FSM states: IDLE, ACCUM, HOLD; in_ready=1 in IDLE and ACCUM, 0 in HOLD; out_valid=1 only in HOLD.
REQ-018 IDLE + transfer: accumulators SHALL load the byte's values (no clear cycle), byte_count=1, then go to ACCUM, or to HOLD if frame complete.
REQ-019 ACCUM + transfer: accumulators add the byte's values, byte_count increments; no transfer: hold all state.
REQ-020 Frame complete on the accepted byte when new byte_count == FRAME_LEN or in_last=1; next state HOLD.
REQ-021 Latency: out_valid SHALL rise the cycle after the clock edge accepting the closing byte.
REQ-022 Bad byte: ones_in>8, zeroes_in>8, or ones_in+zeroes_in != 8; counted in byte_count, contributes 0 to both totals, sets err.
REQ-023 err SHALL be sticky within a frame and cleared when the next frame's first byte is accepted (err then reflects that byte only).
REQ-024 HOLD: total_ones, total_zeroes, byte_count, err SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 HOLD + out_ready=1: go to IDLE; out_valid=0 next cycle; outputs keep last values until next frame's first transfer.
REQ-026 in_valid while in HOLD SHALL be ignored (no accept, no state change); upstream must hold data.
REQ-027 FRAME_LEN=1: every accepted byte closes a frame, IDLE -> HOLD directly.
REQ-028 For good frames total_ones + total_zeroes SHALL equal 8*byte_count.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, in_ready=1, out_valid=0, total_ones=0, total_zeroes=0, byte_count=0, err=0.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial/pending frame; no result emitted for it.
REQ-031 First transfer possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 FRAME_LEN=16, 16 bytes ones_in=3/zeroes_in=5, out_ready=1 -> one out_valid pulse, total_ones=48, total_zeroes=80, byte_count=16, err=0.
REQ-033 Frame of 4 bytes (ones 8,0,1,7) with in_last on 4th -> totals 16/16, byte_count=4, out_valid one cycle after 4th accept.
REQ-034 Byte ones_in=9/zeroes_in=0 inside a 3-byte in_last frame of 2,2 -> total_ones=4, total_zeroes=12, byte_count=3, err=1; next frame err=0.
REQ-035 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, outputs frozen, no byte accepted; out_ready=1 -> IDLE, next byte starts new frame at byte_count=1.
REQ-036 rst_n pulsed low after 7 accepted bytes -> all outputs 0 asynchronously; following full 16-byte frame reports only post-reset bytes.
REQ-037 FRAME_LEN=1, back-to-back in_valid, out_ready=1 -> one frame every 2 cycles, each byte's counts reported alone.
